// File: rtl/wb_stream_loader_pkg.sv
// Shared types for the Wishbone stream loader: FSM states, byte-lane index and bus constants.
package wb_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_FINISH
  } state_e;

  typedef logic [1:0] lane_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam int         LANES      = 4;

endpackage

// File: rtl/wb_stream_loader_packer.sv
// Packs a byte stream little-endian into 32-bit words; holds the word until taken or cleared.
module stream_byte_packer
  import wb_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_taken_i
);

  lane_t       lane_q, lane_d;
  logic [31:0] data_q, data_d;
  logic        full_q, full_d;
  logic        accept;

  assign byte_ready_o = enable_i & ~full_q;
  assign accept       = byte_valid_i & byte_ready_o;
  // Pulses in the cycle the fourth byte is accepted, so the bus cycle can start right after.
  assign word_valid_o = accept & (lane_q == lane_t'(LANES - 1));
  assign word_o       = data_q;

  always_comb begin
    lane_d = lane_q;
    data_d = data_q;
    full_d = full_q;
    if (clear_i || word_taken_i) begin
      lane_d = '0;
      full_d = 1'b0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_q == lane_t'(i)) data_d[8*i +: 8] = byte_i;
      end
      lane_d = lane_t'(lane_q + 2'd1);
      if (word_valid_o) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lane_q <= '0;
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      data_q <= data_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/wb_stream_loader.sv
// Wishbone classic write master that streams packed bytes into consecutive RAM words.
module wb_stream_loader
  import wb_loader_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      base_adr_i,
  input  logic [LEN_W-1:0] len_words_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_o
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             start_ok, wr_ack, wr_err, tmo_hit, last_word;
  logic             pk_word_valid;
  logic [31:0]      pk_word;

  assign start_ok  = (state_q == ST_IDLE) && start_i;
  // A simultaneous err beats ack; the timeout only fires when the responder stayed silent.
  assign wr_err    = (state_q == ST_WRITE) && wbm_err_i;
  assign wr_ack    = (state_q == ST_WRITE) && wbm_ack_i && !wbm_err_i;
  assign tmo_hit   = (TIMEOUT != 0) && (state_q == ST_WRITE) && !wbm_ack_i && !wbm_err_i &&
                     (tmo_q == TMO_W'(TIMEOUT - 1));
  assign last_word = (words_q + LEN_W'(1)) == len_q;

  stream_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (start_ok || wr_err || tmo_hit),
    .enable_i     (state_q == ST_COLLECT),
    .byte_i       (s_data_i),
    .byte_valid_i (s_valid_i),
    .byte_ready_o (s_ready_o),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid),
    .word_taken_i (wr_ack)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_i) state_d = (len_words_i == '0) ? ST_FINISH : ST_COLLECT;
      ST_COLLECT: if (pk_word_valid) state_d = ST_WRITE;
      ST_WRITE: begin
        if (wr_err || tmo_hit) state_d = ST_FINISH;
        else if (wr_ack)       state_d = last_word ? ST_FINISH : ST_COLLECT;
      end
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    done_o    = (state_q == ST_FINISH);
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    if (state_q == ST_WRITE) begin
      wbm_cyc_o = 1'b1;
      wbm_stb_o = 1'b1;
      wbm_we_o  = 1'b1;
      wbm_sel_o = WB_SEL_ALL;
      wbm_adr_o = base_q + (32'(words_q) << 2);
      wbm_dat_o = pk_word;
    end
  end

  always_comb begin
    base_d  = base_q;
    len_d   = len_q;
    words_d = words_q;
    err_d   = err_q;
    tmo_d   = (state_q == ST_WRITE) ? tmo_q + 1'b1 : '0;
    if (start_ok) begin
      base_d  = {base_adr_i[31:2], 2'b00};
      len_d   = len_words_i;
      words_d = '0;
      err_d   = 1'b0;
    end
    if (wr_ack)            words_d = words_q + LEN_W'(1);
    if (wr_err || tmo_hit) err_d   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      base_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      base_q  <= base_d;
      len_q   <= len_d;
      words_q <= words_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign err_o   = err_q;
  assign words_o = words_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed table-driven bench for wb_stream_loader with a Wishbone responder and byte-stream source.
module tb_wb_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] base_adr_i;
  logic [15:0] len_words_i;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic        wbm_ack_i, wbm_err_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          waits;
    int          errAt;
    bit          hang;
    bit          stray;
    int          gapMax;
    logic [7:0]  byteBase;
    logic [15:0] expWords;
    logic        expErr;
    int          expStb;
    int          expWr;
    logic [31:0] adr0, dat0, adrL, datL;
  } vec_t;

  vec_t vecs[6];

  int          rspWaits = 0, rspErrAt = -1, gapMax = 0;
  bit          rspHang = 0, rspStray = 0, streamOn = 0;
  logic [7:0]  byteBase = 8'h00;
  logic [31:0] curBase = 32'h0;
  int          byteIdx = 0, busWord = 0, curRun = 0, stbTotal = 0, wrCount = 0;
  bit          pendingAccept = 0, gapPending = 0;
  logic [31:0] heldAdr, heldDat, firstAdr, firstDat, lastAdr, lastDat;

  wb_stream_loader dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start_i),
    .base_adr_i  (base_adr_i),
    .len_words_i (len_words_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .words_o     (words_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] modelWord(input logic [7:0] b, input int w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b + 8'(4*w + i);
    return r;
  endfunction

  // Byte source: offers consecutive bytes, advancing only when the loader accepted one.
  always @(negedge clk) begin
    if (pendingAccept) byteIdx++;
    pendingAccept = 1'b0;
    if (streamOn) begin
      s_valid_i = (gapMax == 0) ? 1'b1 : ($urandom_range(gapMax, 0) != 0);
      s_data_i  = byteBase + 8'(byteIdx);
      pendingAccept = s_valid_i && s_ready_o;
    end else begin
      s_valid_i = 1'b0;
    end
  end

  // Responder: answers after rspWaits stall cycles, checks bus rules and every written word.
  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (gapPending) begin
      checkOutput("busGap", 32'(wbm_cyc_o), 32'h0);
      gapPending = 1'b0;
    end
    if (wbm_stb_o) checkOutput("stbNeedsCyc", 32'(wbm_cyc_o), 32'h1);
    if (wbm_cyc_o && wbm_stb_o) begin
      curRun++;
      stbTotal++;
      if (curRun == 1) begin
        heldAdr = wbm_adr_o;
        heldDat = wbm_dat_o;
        checkOutput("selWe", 32'({wbm_sel_o, wbm_we_o}), 32'h1F);
      end else begin
        checkOutput("adrStable", wbm_adr_o, heldAdr);
        checkOutput("datStable", wbm_dat_o, heldDat);
      end
      if (!rspHang && curRun > rspWaits) begin
        if (busWord == rspErrAt) begin
          wbm_err_i = 1'b1;
        end else begin
          wbm_ack_i = 1'b1;
          checkOutput("wrAdr", wbm_adr_o, curBase + 32'(busWord * 4));
          checkOutput("wrDat", wbm_dat_o, modelWord(byteBase, busWord));
          if (wrCount == 0) begin
            firstAdr = wbm_adr_o;
            firstDat = wbm_dat_o;
          end
          lastAdr = wbm_adr_o;
          lastDat = wbm_dat_o;
          wrCount++;
          busWord++;
          gapPending = 1'b1;
        end
      end
    end else begin
      curRun = 0;
      if (rspStray) begin
        wbm_ack_i = 1'($urandom_range(1, 0));
        wbm_err_i = 1'($urandom_range(1, 0));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    bit seen;
    $display("[TB] vector base=0x%08h len=%0d", v.base, v.len);
    rspWaits = v.waits;
    rspErrAt = v.errAt;
    rspHang  = v.hang;
    rspStray = v.stray;
    gapMax   = v.gapMax;
    byteBase = v.byteBase;
    curBase  = {v.base[31:2], 2'b00};
    byteIdx  = 0;
    busWord  = 0;
    stbTotal = 0;
    wrCount  = 0;
    pendingAccept = 1'b0;
    start_i     = 1'b1;
    base_adr_i  = v.base;
    len_words_i = v.len;
    streamOn    = 1'b1;
    tick();
    start_i     = 1'b0;
    base_adr_i  = 32'hDEAD_0000;
    len_words_i = 16'd7;
    checkOutput("startClr", 32'({err_o, words_o}), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      start_i = (k == 2);
      tick();
    end
    start_i = 1'b0;
    checkOutput("doneSeen", 32'(seen), 32'h1);
    checkOutput("words", 32'(words_o), 32'(v.expWords));
    checkOutput("errFlag", 32'(err_o), 32'(v.expErr));
    checkOutput("busyAtDone", 32'(busy_o), 32'h0);
    checkOutput("writeCount", 32'(wrCount), 32'(v.expWr));
    checkOutput("stbCycles", 32'(stbTotal), 32'(v.expStb));
    if (v.expWr > 0) begin
      checkOutput("firstAdr", firstAdr, v.adr0);
      checkOutput("firstDat", firstDat, v.dat0);
      checkOutput("lastAdr", lastAdr, v.adrL);
      checkOutput("lastDat", lastDat, v.datL);
    end
    tick();
    checkOutput("donePulse", 32'(done_o), 32'h0);
    checkOutput("readyAfter", 32'(s_ready_o), 32'h0);
    checkOutput("busIdle", 32'(wbm_cyc_o), 32'h0);
    streamOn = 1'b0;
    rspStray = 1'b0;
  endtask

  initial begin
    bit seen;
    vecs[0] = '{32'h0000_0100, 16'd2, 1, -1, 1'b0, 1'b0, 0, 8'h01, 16'd2, 1'b0, 4, 2,
                32'h0000_0100, 32'h0403_0201, 32'h0000_0104, 32'h0807_0605};
    vecs[1] = '{32'h0000_0200, 16'd0, 0, -1, 1'b0, 1'b0, 0, 8'h00, 16'd0, 1'b0, 0, 0,
                32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{32'h0000_0040, 16'd3, 0, 1, 1'b0, 1'b0, 0, 8'h10, 16'd1, 1'b1, 2, 1,
                32'h0000_0040, 32'h1312_1110, 32'h0000_0040, 32'h1312_1110};
    vecs[3] = '{32'hFFFF_FFFC, 16'd2, 2, -1, 1'b0, 1'b0, 3, 8'hA0, 16'd2, 1'b0, 6, 2,
                32'hFFFF_FFFC, 32'hA3A2_A1A0, 32'h0000_0000, 32'hA7A6_A5A4};
    vecs[4] = '{32'h0000_1003, 16'd1, 0, -1, 1'b0, 1'b1, 0, 8'hF0, 16'd1, 1'b0, 1, 1,
                32'h0000_1000, 32'hF3F2_F1F0, 32'h0000_1000, 32'hF3F2_F1F0};
    vecs[5] = '{32'h0000_0300, 16'd1, 0, -1, 1'b1, 1'b0, 0, 8'h55, 16'd0, 1'b1, 255, 0,
                32'h0, 32'h0, 32'h0, 32'h0};

    rst_n       = 1'b0;
    start_i     = 1'b0;
    base_adr_i  = '0;
    len_words_i = '0;
    s_data_i    = '0;
    s_valid_i   = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_err_i   = 1'b0;
    tick();
    tick();
    checkOutput("rstCtrl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, done_o, err_o, s_ready_o}), 32'h0);
    checkOutput("rstAdr", wbm_adr_o, 32'h0);
    checkOutput("rstDat", wbm_dat_o, 32'h0);
    checkOutput("rstWords", 32'(words_o), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset asserted while a write is stalled must drop the bus without waiting for a clock edge.
    rspHang  = 1'b1;
    rspErrAt = -1;
    rspWaits = 0;
    gapMax   = 0;
    byteBase = 8'h30;
    curBase  = 32'h0000_0500;
    byteIdx  = 0;
    busWord  = 0;
    start_i     = 1'b1;
    base_adr_i  = 32'h0000_0500;
    len_words_i = 16'd2;
    streamOn    = 1'b1;
    tick();
    start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (wbm_cyc_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("reachWrite", 32'(seen), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstBus", 32'({wbm_cyc_o, wbm_stb_o, busy_o}), 32'h0);
    streamOn = 1'b0;
    rspHang  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
